// File: rtl/cursor_blink.sv
// Text-cursor blink controller: turns the prescaler's slow square wave into
// single-cycle ticks and drives a blink / hold-solid cursor FSM from them.
module cursor_blink #(
  parameter int unsigned ON_TICKS   = 2,
  parameter int unsigned OFF_TICKS  = 2,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned CW         = 4
) (
  input  logic       clk_in,
  input  logic       rstn,
  input  logic       en,
  input  logic       presc_in,
  input  logic       activity,
  output logic       tick,
  output logic       cursor_on,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ON   = 2'b01;
  localparam logic [1:0] S_OFF  = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b11;

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);

  logic          presc_q;
  logic          step_c;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    state_next;

  // presc_q resets high so a prescaler already high at reset release is not an edge
  assign step_c = en & presc_in & ~presc_q;

  // State, counter and registered outputs
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      presc_q   <= 1'b1;
      cnt       <= '0;
      state     <= S_IDLE;
      tick      <= 1'b0;
      cursor_on <= 1'b0;
    end else begin
      presc_q   <= presc_in;
      cnt       <= cnt_next;
      state     <= state_next;
      tick      <= step_c;
      cursor_on <= (state_next == S_ON) || (state_next == S_HOLD);
    end
  end

  // Next-state: en=0 parks, activity forces hold (same-cycle step dropped), else tick-driven
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!en) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else if (activity) begin
      state_next = S_HOLD;
      cnt_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_next = S_ON;
          cnt_next   = '0;
        end
        S_ON: begin
          if (step_c) begin
            if (cnt == ON_LAST) begin
              state_next = S_OFF;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
        S_OFF: begin
          if (step_c) begin
            if (cnt == OFF_LAST) begin
              state_next = S_ON;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
        default: begin
          if (step_c) begin
            if (cnt == HOLD_LAST) begin
              state_next = S_ON;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_blink.sv
// Self-checking bench for cursor_blink: vector table plus hand-written
// sequences for async reset and enable corner cases, checked via a scoreboard queue.
module tb_cursor_blink;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ON   = 2'b01;
  localparam logic [1:0] S_OFF  = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b11;

  logic       clk_in = 1'b0;
  logic       rstn;
  logic       en;
  logic       presc_in;
  logic       activity;
  logic       tick;
  logic       cursor_on;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       presc;
    logic       act;
    logic       tick;
    logic [1:0] st;
    string      name;
  } vec_t;

  typedef struct {
    logic       tick;
    logic       cur;
    logic [1:0] st;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  cursor_blink #(.ON_TICKS(2), .OFF_TICKS(2), .HOLD_TICKS(4), .CW(4)) dut (
    .clk_in    (clk_in),
    .rstn      (rstn),
    .en        (en),
    .presc_in  (presc_in),
    .activity  (activity),
    .tick      (tick),
    .cursor_on (cursor_on),
    .state     (state)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Cursor is drawn in ON and HOLD only
  function automatic logic visible(logic [1:0] s);
    return (s == S_ON) || (s == S_HOLD);
  endfunction

  function automatic void add(int n, logic e, logic p, logic a, logic t, logic [1:0] s, string nm);
    vec_t v;
    v.en = e; v.presc = p; v.act = a; v.tick = t; v.st = s; v.name = nm;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // One 16-cycle prescaler period: 8 low, then a rising edge producing one tick
  function automatic void add_period(logic [1:0] sb, logic [1:0] sa, string nm);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, sb, nm);
    add(1, 1'b1, 1'b1, 1'b0, 1'b1, sa, nm);
    add(7, 1'b1, 1'b1, 1'b0, 1'b0, sa, nm);
  endfunction

  task automatic chk(string nm, logic [1:0] got, logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  // Called just after a negedge: drive, push expectation, check after the posedge
  task automatic apply(logic e, logic p, logic a, logic t, logic [1:0] s, string nm);
    exp_t x;
    en = e; presc_in = p; activity = a;
    x.tick = t; x.cur = visible(s); x.st = s; x.name = nm;
    exp_q.push_back(x);
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: got empty scoreboard want entry", nm);
    end else begin
      x = exp_q.pop_front();
      chk({x.name, "_tick"}, {1'b0, tick}, {1'b0, x.tick});
      chk({x.name, "_cur"}, {1'b0, cursor_on}, {1'b0, x.cur});
      chk({x.name, "_state"}, state, x.st);
    end
    @(negedge clk_in);
  endtask

  initial begin
    // Reset held with prescaler high; release must not create a tick
    add(10, 1'b1, 1'b1, 1'b0, 1'b0, S_ON, "t1_presc_high");
    // Steady blink: 2 ticks visible, 2 hidden
    add_period(S_ON, S_ON, "t2_p1");
    add_period(S_ON, S_OFF, "t2_p2");
    add_period(S_OFF, S_OFF, "t2_p3");
    add_period(S_OFF, S_ON, "t2_p4");
    add_period(S_ON, S_ON, "t2_p5");
    add_period(S_ON, S_OFF, "t2_p6");
    // Activity while OFF: solid for exactly 4 ticks, then ON
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, S_HOLD, "t3_act");
    add(7, 1'b1, 1'b1, 1'b0, 1'b0, S_HOLD, "t3_act_wait");
    for (int i = 0; i < 3; i++) add_period(S_HOLD, S_HOLD, "t3_hold");
    add_period(S_HOLD, S_ON, "t3_hold_end");
    // Activity coincident with a step in HOLD at its last count: restart
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, S_HOLD, "t4_act");
    add(7, 1'b1, 1'b1, 1'b0, 1'b0, S_HOLD, "t4_act_wait");
    for (int i = 0; i < 3; i++) add_period(S_HOLD, S_HOLD, "t4_to_cnt3");
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, S_HOLD, "t4_lo");
    add(1, 1'b1, 1'b1, 1'b1, 1'b1, S_HOLD, "t4_act_step");
    add(7, 1'b1, 1'b1, 1'b0, 1'b0, S_HOLD, "t4_restart");
    for (int i = 0; i < 3; i++) add_period(S_HOLD, S_HOLD, "t4_hold");
    add_period(S_HOLD, S_ON, "t4_hold_end");
    // Enable dropped in ON with cnt=1, then restored with cnt cleared
    add_period(S_ON, S_ON, "t5_cnt1");
    add(1, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, "t5_en_off");
    add(1, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, "t5_idle_lo");
    add(1, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, "t5_idle_edge");
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, S_ON, "t5_en_on");
    add_period(S_ON, S_ON, "t5_p1");
    add_period(S_ON, S_OFF, "t5_p2");

    rstn = 1'b0; en = 1'b1; presc_in = 1'b1; activity = 1'b0;
    #2;
    chk("reset_tick", {1'b0, tick}, 2'b00);
    chk("reset_cur", {1'b0, cursor_on}, 2'b00);
    chk("reset_state", state, S_IDLE);
    @(negedge clk_in);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].en, vecs[i].presc, vecs[i].act, vecs[i].tick, vecs[i].st, vecs[i].name);

    // Activity straight out of IDLE goes to HOLD
    apply(1'b0, 1'b1, 1'b0, 1'b0, S_IDLE, "idle_park");
    apply(1'b1, 1'b1, 1'b1, 1'b0, S_HOLD, "idle_act");
    for (int i = 0; i < 8; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, S_HOLD, "t6_lo");
    apply(1'b1, 1'b1, 1'b0, 1'b1, S_HOLD, "t6_tick");

    // Async reset between edges while tick and cursor_on are high
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_tick", {1'b0, tick}, 2'b00);
    chk("t6_async_cur", {1'b0, cursor_on}, 2'b00);
    chk("t6_async_state", state, S_IDLE);
    @(posedge clk_in);
    #1;
    chk("t6_held_state", state, S_IDLE);
    chk("t6_held_cur", {1'b0, cursor_on}, 2'b00);
    @(negedge clk_in);
    rstn = 1'b1;
    apply(1'b1, 1'b1, 1'b0, 1'b0, S_ON, "t6_release");
    apply(1'b1, 1'b0, 1'b0, 1'b0, S_ON, "t6_rel_lo");
    apply(1'b1, 1'b1, 1'b0, 1'b1, S_ON, "t6_rel_tick");
    apply(1'b1, 1'b1, 1'b0, 1'b0, S_ON, "t6_rel_stuck");

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
